vc_output_arbiter: RTL and testbench

Per-output-port switch scheduler for the virtual channel router. It shares one output link among NUM_VC input virtual channels and drives the enable of the output-stage pipe_register. It uses round-robin arbitration on packet heads and holds the grant for the whole packet (wormhole lock). Per-VC credit counters track free slots in the downstream buffer, so a flit is only granted when space exists.

---
 rtl/vc_output_arbiter.sv | 143 ++++++++++++++
 tb/tb_vc_output_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_output_arbiter.sv
// vc_output_arbiter: per-output-port switch scheduler for the VC router.
// Round-robin over packet heads with a wormhole lock held until the tail,
// gated by per-VC downstream credit counters. The grant is combinational
// from registered state and request inputs; credit_ret only reaches the
// grant through the registered credit counters.
//
// state  | meaning
// S_IDLE | link free; arbitrate among eligible head flits from rr_ptr
// S_LOCKED | multi-flit packet from owner holds the link until its tail
module vc_output_arbiter #(
  parameter  int NUM_VC    = 4,
  parameter  int BUF_DEPTH = 4,
  localparam int IDXW      = $clog2(NUM_VC),
  localparam int CRW       = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_VC-1:0] req,
  input  logic [NUM_VC-1:0] head,
  input  logic [NUM_VC-1:0] tail,
  input  logic [NUM_VC-1:0] credit_ret,
  output logic [NUM_VC-1:0] grant,
  output logic              grant_valid,
  output logic [IDXW-1:0]   grant_idx,
  output logic              pipe_enable,
  output logic              locked,
  output logic              credit_err
);

  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t          state;
  logic [IDXW-1:0] owner;
  logic [IDXW-1:0] rr_ptr;
  logic [CRW-1:0]  credit [NUM_VC];

  logic [NUM_VC-1:0] eligible;
  logic [NUM_VC-1:0] grant_c;
  logic              win_any;
  logic [IDXW-1:0]   win_idx;

  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] idx);
    return IDXW'((int'(idx) + 1) % NUM_VC);
  endfunction

  // A VC may only be granted when it requests and has downstream space.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      eligible[i] = req[i] && (credit[i] != '0);
    end
  end

  // Winner selection: rotating scan over heads when idle, owner-only when locked.
  always_comb begin
    logic [IDXW-1:0] cand;
    win_any = 1'b0;
    win_idx = '0;
    cand    = '0;
    if (state == S_IDLE) begin
      for (int k = 0; k < NUM_VC; k++) begin
        cand = IDXW'((int'(rr_ptr) + k) % NUM_VC);
        if (!win_any && eligible[cand] && head[cand]) begin
          win_any = 1'b1;
          win_idx = cand;
        end
      end
    end else if (eligible[owner]) begin
      win_any = 1'b1;
      win_idx = owner;
    end
    if (reset) begin
      win_any = 1'b0;
      win_idx = '0;
    end
  end

  // One-hot grant and derived status outputs, all quiet during reset.
  always_comb begin
    grant_c = '0;
    if (win_any) begin
      grant_c[win_idx] = 1'b1;
    end
    grant       = grant_c;
    grant_valid = win_any;
    grant_idx   = win_any ? win_idx : '0;
    pipe_enable = win_any;
    locked      = (state == S_LOCKED) && !reset;
  end

  // Lock / round-robin pointer FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_any) begin
            if (tail[win_idx]) begin
              rr_ptr <= next_idx(win_idx);
            end else begin
              state <= S_LOCKED;
              owner <= win_idx;
            end
          end
        end
        S_LOCKED: begin
          if (win_any && tail[owner]) begin
            state  <= S_IDLE;
            rr_ptr <= next_idx(owner);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Credit counters: grant consumes a slot, credit_ret frees one; both cancel.
  // A return into a full counter is a downstream protocol error and is sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_VC; i++) begin
        credit[i] <= CRW'(BUF_DEPTH);
      end
      credit_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        if (grant_c[i] && !credit_ret[i]) begin
          credit[i] <= credit[i] - CRW'(1);
        end else if (credit_ret[i] && !grant_c[i]) begin
          if (credit[i] == CRW'(BUF_DEPTH)) begin
            credit_err <= 1'b1;
          end else begin
            credit[i] <= credit[i] + CRW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vc_output_arbiter.sv
// Self-checking bench for vc_output_arbiter (NUM_VC=4, BUF_DEPTH=4).
module tb_vc_output_arbiter;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req, head, tail, credit_ret;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_idx;
  logic         pipe_enable;
  logic         locked;
  logic         credit_err;

  int n_checks = 0;
  int n_fail   = 0;

  vc_output_arbiter #(.NUM_VC(N), .BUF_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .req(req), .head(head), .tail(tail),
    .credit_ret(credit_ret), .grant(grant), .grant_valid(grant_valid),
    .grant_idx(grant_idx), .pipe_enable(pipe_enable), .locked(locked),
    .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  // Reference model: packet-level view of the link.
  bit m_locked = 1'b0;
  int m_owner  = 0;
  int m_rr     = 0;
  int m_cr [N] = '{D, D, D, D};
  bit m_err    = 1'b0;

  function automatic logic [N-1:0] exp_grant();
    if (reset) return '0;
    if (!m_locked) begin
      for (int k = 0; k < N; k++) begin
        int j = (m_rr + k) % N;
        if (req[j] && head[j] && m_cr[j] > 0) return N'(1 << j);
      end
      return '0;
    end
    if (req[m_owner] && m_cr[m_owner] > 0) return N'(1 << m_owner);
    return '0;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) begin
    logic [N-1:0] g;
    int w;
    if (reset) begin
      m_locked = 1'b0; m_owner = 0; m_rr = 0; m_err = 1'b0;
      for (int i = 0; i < N; i++) m_cr[i] = D;
    end else begin
      g = exp_grant();
      w = onehot_idx(g);
      if (g != '0) begin
        if (!m_locked && !tail[w]) begin
          m_locked = 1'b1; m_owner = w;
        end else if (tail[w]) begin
          m_locked = 1'b0; m_rr = (w + 1) % N;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (g[i] && !credit_ret[i]) m_cr[i]--;
        else if (credit_ret[i] && !g[i]) begin
          if (m_cr[i] == D) m_err = 1'b1;
          else m_cr[i]++;
        end
      end
    end
  end

  // Drive one cycle of inputs just after the falling edge, settle, return.
  task automatic cyc(input logic r, input logic [N-1:0] q, input logic [N-1:0] h,
                     input logic [N-1:0] t, input logic [N-1:0] c);
    @(negedge clk);
    reset = r; req = q; head = h; tail = t; credit_ret = c;
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      cyc(1'b1, 4'hF, 4'hF, 4'hF, 4'h0);
      n_checks++;
      if (grant !== 4'b0000 || pipe_enable !== 1'b0 || locked !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: grant=%b pipe_enable=%b locked=%b, want 0000/0/0",
                 grant, pipe_enable, locked);
      end
    end
    cyc(1'b0, 4'hF, 4'hF, 4'hF, 4'h0);
    n_checks++;
    if (grant !== 4'b0001 || grant_idx !== 2'd0 || grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_grant: grant=%b idx=%0d valid=%b, want 0001/0/1",
               grant, grant_idx, grant_valid);
    end
    n_checks++;
    if (credit_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_credit_err: got %b want 0", credit_err);
    end
  endtask

  task automatic test_round_robin();
    int seq [5] = '{0, 1, 2, 3, 0};
    cyc(1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int c = 0; c < 5; c++) begin
      cyc(1'b0, 4'hF, 4'hF, 4'hF, N'(1 << seq[c]));
      n_checks++;
      if (grant_idx !== 2'(seq[c]) || grant !== N'(1 << seq[c])) begin
        n_fail++;
        $display("FAIL rr_seq[%0d]: idx=%0d grant=%b, want idx=%0d", c, grant_idx, grant, seq[c]);
      end
    end
    // Credits unchanged: each VC can still take four flits without returns.
    for (int c = 0; c < 5; c++) begin
      cyc(1'b0, 4'b1000, 4'b1000, 4'b1000, 4'h0);
      n_checks++;
      if (grant !== ((c < 4) ? 4'b1000 : 4'b0000)) begin
        n_fail++;
        $display("FAIL rr_credit_vc3[%0d]: grant=%b", c, grant);
      end
    end
    n_checks++;
    if (credit_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_credit_err: got %b want 0", credit_err);
    end
  endtask

  task automatic test_wormhole();
    logic [N-1:0] h1 [3] = '{4'b0010, 4'b0000, 4'b0000};
    logic [N-1:0] t1 [3] = '{4'b0000, 4'b0000, 4'b0010};
    logic         lk [3] = '{1'b0, 1'b1, 1'b1};
    cyc(1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int c = 0; c < 3; c++) begin
      cyc(1'b0, 4'b1110, 4'b1100 | h1[c], 4'b1100 | t1[c], 4'h0);
      n_checks++;
      if (grant_idx !== 2'd1 || grant_valid !== 1'b1 || locked !== lk[c]) begin
        n_fail++;
        $display("FAIL worm_flit[%0d]: idx=%0d valid=%b locked=%b, want 1/1/%b",
                 c, grant_idx, grant_valid, locked, lk[c]);
      end
    end
    cyc(1'b0, 4'b1100, 4'b1100, 4'b1100, 4'h0);
    n_checks++;
    if (grant !== 4'b0100 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL worm_next: grant=%b locked=%b, want 0100/0", grant, locked);
    end
  endtask

  task automatic test_credit_stall();
    cyc(1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int c = 0; c < 6; c++) begin
      cyc(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'h0);
      n_checks++;
      if (grant !== ((c < 4) ? 4'b0001 : 4'b0000)) begin
        n_fail++;
        $display("FAIL stall_flit[%0d]: grant=%b", c, grant);
      end
    end
    cyc(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0001);
    n_checks++;
    if (grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL stall_ret_same_cycle: grant=%b want 0000", grant);
    end
    cyc(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'h0);
    n_checks++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL stall_ret_next_cycle: grant=%b want 0001", grant);
    end
  endtask

  task automatic test_credit_simul();
    logic [N-1:0] want;
    cyc(1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    cyc(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'h0);
    cyc(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'h0);
    cyc(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0001);
    n_checks++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL simul_grant: grant=%b want 0001", grant);
    end
    // Credit should still be 2: two more grants, then stall.
    for (int c = 0; c < 3; c++) begin
      want = (c < 2) ? 4'b0001 : 4'b0000;
      cyc(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'h0);
      n_checks++;
      if (grant !== want) begin
        n_fail++;
        $display("FAIL simul_remaining[%0d]: grant=%b want %b", c, grant, want);
      end
    end
    cyc(1'b0, 4'h0, 4'h0, 4'h0, 4'b1000);
    n_checks++;
    if (credit_err !== 1'b0) begin
      n_fail++;
      $display("FAIL overret_before: credit_err=%b want 0", credit_err);
    end
    for (int c = 0; c < 3; c++) begin
      cyc(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      n_checks++;
      if (credit_err !== 1'b1) begin
        n_fail++;
        $display("FAIL overret_sticky[%0d]: credit_err=%b want 1", c, credit_err);
      end
    end
    cyc(1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    cyc(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    n_checks++;
    if (credit_err !== 1'b0) begin
      n_fail++;
      $display("FAIL overret_cleared: credit_err=%b want 0", credit_err);
    end
  endtask

  task automatic test_reset_mid_packet();
    cyc(1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    cyc(1'b0, 4'b0100, 4'b0100, 4'b0000, 4'h0);
    n_checks++;
    if (grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL mid_head: grant=%b want 0100", grant);
    end
    cyc(1'b1, 4'b0100, 4'b0000, 4'b0000, 4'h0);
    n_checks++;
    if (grant !== 4'b0000 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_in_reset: grant=%b locked=%b want 0000/0", grant, locked);
    end
    cyc(1'b0, 4'b0100, 4'b0000, 4'b0000, 4'h0);
    n_checks++;
    if (grant !== 4'b0000 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_body_after: grant=%b locked=%b want 0000/0", grant, locked);
    end
    for (int c = 0; c < 5; c++) begin
      cyc(1'b0, 4'b0100, 4'b0100, 4'b0100, 4'h0);
      n_checks++;
      if (grant !== ((c < 4) ? 4'b0100 : 4'b0000)) begin
        n_fail++;
        $display("FAIL mid_credit_restored[%0d]: grant=%b", c, grant);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] c_ret, eg;
    logic         r;
    cyc(1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 49) == 0);
      c_ret = '0;
      for (int i = 0; i < N; i++) begin
        if ((m_cr[i] < D && $urandom_range(0, 2) == 0) || $urandom_range(0, 199) == 0)
          c_ret[i] = 1'b1;
      end
      cyc(r, N'($urandom), N'($urandom), N'($urandom), c_ret);
      eg = exp_grant();
      n_checks++;
      if (grant !== eg || grant_valid !== (eg != '0) || pipe_enable !== (eg != '0) ||
          grant_idx !== 2'(onehot_idx(eg))) begin
        n_fail++;
        $display("FAIL rand_grant[%0d]: grant=%b valid=%b pe=%b idx=%0d, want %b",
                 n, grant, grant_valid, pipe_enable, grant_idx, eg);
      end
      n_checks++;
      if (locked !== (m_locked && !r) || credit_err !== m_err) begin
        n_fail++;
        $display("FAIL rand_status[%0d]: locked=%b err=%b, want %b/%b",
                 n, locked, credit_err, m_locked && !r, m_err);
      end
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; head = '0; tail = '0; credit_ret = '0;
    test_reset();
    test_round_robin();
    test_wormhole();
    test_credit_stall();
    test_credit_simul();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
